multicycle_control: RTL

- Main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback for R-type, lw, sw, beq, j and addi.
- Drives the datapath mux selects, the register-file and memory strobes, and the 3-bit ALUOp consumed by the ALU control decoder.
- Stalls on a memory ready handshake.
- Flags illegal opcodes.

---
 rtl/mips_ctrl_pkg.sv | 51 +++++
 rtl/mc_next_state.sv | 48 ++++
 rtl/multicycle_control.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: state encoding,
// opcodes, ALUOp codes and datapath select values. The ALU control decoder
// imports the same constants so both sides agree on the encodings.
package mips_ctrl_pkg;

  localparam int OPC_W   = 6;
  localparam int ALUOP_W = 3;
  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_R_EXEC   = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_I_EXEC   = 4'd10,
    ST_I_WB     = 4'd11
  } state_t;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'b010;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for the opcodes this control path knows how to sequence.
  function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_next_state.sv
// Next-state function of the multicycle control FSM. Purely combinational:
// the live opcode is only looked at in DECODE, the held copy in MEM_ADDR.
module mc_next_state
  import mips_ctrl_pkg::*;
(
  input  logic [STATE_W-1:0] i_state,
  input  logic [OPC_W-1:0]   i_opcode,
  input  logic [OPC_W-1:0]   i_heldOpcode,
  input  logic               i_memReady,
  output logic [STATE_W-1:0] o_nextState
);

  state_t w_state;
  state_t w_next;

  assign w_state     = state_t'(i_state);
  assign o_nextState = w_next;

  // Transition table; unused encodings and illegal opcodes fall back to FETCH.
  always_comb begin
    w_next = ST_FETCH;
    case (w_state)
      ST_FETCH:    w_next = i_memReady ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (i_opcode)
          OP_RTYPE:     w_next = ST_R_EXEC;
          OP_LW, OP_SW: w_next = ST_MEM_ADDR;
          OP_BEQ:       w_next = ST_BRANCH;
          OP_J:         w_next = ST_JUMP;
          OP_ADDI:      w_next = ST_I_EXEC;
          default:      w_next = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR: w_next = (i_heldOpcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   w_next = i_memReady ? ST_MEM_WB : ST_MEM_RD;
      ST_MEM_WB:   w_next = ST_FETCH;
      ST_MEM_WR:   w_next = i_memReady ? ST_FETCH : ST_MEM_WR;
      ST_R_EXEC:   w_next = ST_R_WB;
      ST_R_WB:     w_next = ST_FETCH;
      ST_BRANCH:   w_next = ST_FETCH;
      ST_JUMP:     w_next = ST_FETCH;
      ST_I_EXEC:   w_next = ST_I_WB;
      ST_I_WB:     w_next = ST_FETCH;
      default:     w_next = ST_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath. Outputs are decoded from
// the current state (plus mem_ready for the handshake-gated strobes) and are
// all forced low while reset is held, so nothing leaks out mid-reset.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  state_t               r_state;
  logic [OPC_W-1:0]     r_heldOpcode;
  logic [STATE_W-1:0]   w_nextState;

  logic                 w_pcWrite, w_pcWriteCond, w_iorD, w_memRead, w_memWrite;
  logic                 w_irWrite, w_memtoReg, w_regDst, w_regWrite, w_aluSrcA;
  logic [1:0]           w_aluSrcB, w_pcSource;
  logic [ALUOP_W-1:0]   w_aluOp;
  logic                 w_instrDone, w_illegalOp;

  mc_next_state u_nextState (
    .i_state      (r_state),
    .i_opcode     (opcode),
    .i_heldOpcode (r_heldOpcode),
    .i_memReady   (mem_ready),
    .o_nextState  (w_nextState)
  );

  // State register; reset drops straight back to FETCH without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= state_t'(w_nextState);
  end

  // Keep the decoded opcode so MEM_ADDR can pick lw/sw even if IR moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_heldOpcode <= '0;
    else if (r_state == ST_DECODE) r_heldOpcode <= opcode;
  end

  // Per-state datapath controls; anything not set for a state stays 0.
  always_comb begin
    w_pcWrite     = 1'b0;
    w_pcWriteCond = 1'b0;
    w_iorD        = 1'b0;
    w_memRead     = 1'b0;
    w_memWrite    = 1'b0;
    w_irWrite     = 1'b0;
    w_memtoReg    = 1'b0;
    w_regDst      = 1'b0;
    w_regWrite    = 1'b0;
    w_aluSrcA     = 1'b0;
    w_aluSrcB     = ALUSRCB_B;
    w_pcSource    = PCSRC_ALU;
    w_aluOp       = ALUOP_ADD;
    w_instrDone   = 1'b0;
    w_illegalOp   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_memRead = 1'b1;
        w_aluSrcB = ALUSRCB_FOUR;
        w_irWrite = mem_ready;
        w_pcWrite = mem_ready;
      end
      ST_DECODE: begin
        w_aluSrcB   = ALUSRCB_IMMSH;
        w_illegalOp = !is_legal_op(opcode);
      end
      ST_MEM_ADDR: begin
        w_aluSrcA = 1'b1;
        w_aluSrcB = ALUSRCB_IMM;
      end
      ST_MEM_RD: begin
        w_memRead = 1'b1;
        w_iorD    = 1'b1;
      end
      ST_MEM_WB: begin
        w_regWrite  = 1'b1;
        w_memtoReg  = 1'b1;
        w_instrDone = 1'b1;
      end
      ST_MEM_WR: begin
        w_memWrite  = 1'b1;
        w_iorD      = 1'b1;
        w_instrDone = mem_ready;
      end
      ST_R_EXEC: begin
        w_aluSrcA = 1'b1;
        w_aluOp   = ALUOP_RTYPE;
      end
      ST_R_WB: begin
        w_regWrite  = 1'b1;
        w_regDst    = 1'b1;
        w_instrDone = 1'b1;
      end
      ST_BRANCH: begin
        w_aluSrcA     = 1'b1;
        w_aluOp       = ALUOP_SUB;
        w_pcWriteCond = 1'b1;
        w_pcSource    = PCSRC_ALUOUT;
        w_instrDone   = 1'b1;
      end
      ST_JUMP: begin
        w_pcWrite   = 1'b1;
        w_pcSource  = PCSRC_JUMP;
        w_instrDone = 1'b1;
      end
      ST_I_EXEC: begin
        w_aluSrcA = 1'b1;
        w_aluSrcB = ALUSRCB_IMM;
      end
      ST_I_WB: begin
        w_regWrite  = 1'b1;
        w_instrDone = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite     = w_pcWrite     & rst_n;
  assign PCWriteCond = w_pcWriteCond & rst_n;
  assign IorD        = w_iorD        & rst_n;
  assign MemRead     = w_memRead     & rst_n;
  assign MemWrite    = w_memWrite    & rst_n;
  assign IRWrite     = w_irWrite     & rst_n;
  assign MemtoReg    = w_memtoReg    & rst_n;
  assign RegDst      = w_regDst      & rst_n;
  assign RegWrite    = w_regWrite    & rst_n;
  assign ALUSrcA     = w_aluSrcA     & rst_n;
  assign ALUSrcB     = rst_n ? w_aluSrcB  : 2'b00;
  assign PCSource    = rst_n ? w_pcSource : 2'b00;
  assign ALUOp       = rst_n ? w_aluOp    : '0;
  assign instr_done  = w_instrDone   & rst_n;
  assign illegal_op  = w_illegalOp   & rst_n;
  assign state_dbg   = rst_n ? r_state  : '0;

endmodule
